// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Access-size encodings and the write-fault cause type.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    MEM_FAULT_NONE         = 2'd0,
    MEM_FAULT_MISALIGNED   = 2'd1,
    MEM_FAULT_OUT_OF_RANGE = 2'd2
  } mem_fault_cause_t;

endpackage

// File: rtl/mem_if.sv
// Memory access interface between a requester and the responder.
// master: responder end (request in, rd_data out); slave: requester end.
interface mem_if;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic [31:0] rd_data;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        wr_enable;

  modport master (
    input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    output rd_data
  );

  modport slave (
    output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    input  rd_data
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// mem_lane_align: byte-lane mask, write replication, read extraction.
// Ports: size_i, addr_i[1:0], wdata_i, rword_i in; be_o, wdata_o, rdata_o, mis_o out.
module mem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        mis_o
);

  logic [31:0] rsh;

  // Selected byte/halfword lands in the low bits.
  assign rsh = rword_i >> {addr_i, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    mis_o   = 1'b1;
    unique case (1'b1)
      size_i == MEM_SIZE_BYTE: begin
        mis_o   = 1'b0;
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rsh[7:0]};
      end
      size_i == MEM_SIZE_HALF: begin
        mis_o   = addr_i[0];
        be_o    = addr_i[0] ? 4'b0000
                : (addr_i[1] ? 4'b1100 : 4'b0011);
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, rsh[15:0]};
      end
      size_i == MEM_SIZE_WORD: begin
        mis_o   = |addr_i;
        be_o    = (|addr_i) ? 4'b0000 : 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enable RAM, tohost halt MMIO, sticky write faults.
// Ports: clk_i, reset_ni, memif (mem_if.master), fault/halt status, wr_count_o.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  mem_if.master            memif,
  output logic             fault_o,
  output mem_fault_cause_t fault_cause_o,
  output logic [31:0]      fault_addr_o,
  output logic             halt_o,
  output logic [31:0]      halt_code_o,
  output logic [31:0]      wr_count_o
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rd_off, wr_off;
  logic        rd_in, wr_in;
  logic [31:0] rd_word, rd_ext;
  logic        rd_mis, rd_tohost;
  logic [3:0]  wr_be;
  logic [31:0] wr_al;
  logic        wr_mis, wr_tohost;
  logic        ram_we;

  logic [3:0]  unused_rd_be;
  logic [31:0] unused_rd_al, unused_wr_rd;
  logic        unused_ok;

  logic             fault_q, fault_d;
  mem_fault_cause_t cause_q, cause_d;
  logic [31:0]      faddr_q, faddr_d;
  logic             halt_q, halt_d;
  logic [31:0]      hcode_q, hcode_d;
  logic [31:0]      wr_cnt_q, wr_cnt_d;

  // Offsets below BASE_ADDR wrap high and fail the span test.
  assign rd_off = memif.rd_addr - BASE_ADDR;
  assign wr_off = memif.wr_addr - BASE_ADDR;
  assign rd_in  = {1'b0, rd_off} < SPAN;
  assign wr_in  = {1'b0, wr_off} < SPAN;

  assign rd_word = mem_q[rd_off[AW+1:2]];

  mem_lane_align u_rd_align (
    .size_i  (memif.rd_size),
    .addr_i  (rd_off[1:0]),
    .wdata_i (32'h0),
    .rword_i (rd_word),
    .be_o    (unused_rd_be),
    .wdata_o (unused_rd_al),
    .rdata_o (rd_ext),
    .mis_o   (rd_mis)
  );

  mem_lane_align u_wr_align (
    .size_i  (memif.wr_size),
    .addr_i  (wr_off[1:0]),
    .wdata_i (memif.wr_data),
    .rword_i (32'h0),
    .be_o    (wr_be),
    .wdata_o (wr_al),
    .rdata_o (unused_wr_rd),
    .mis_o   (wr_mis)
  );

  assign unused_ok = ^{unused_rd_be, unused_rd_al, unused_wr_rd};

  assign rd_tohost = (memif.rd_addr == TOHOST_ADDR)
                  && (memif.rd_size == MEM_SIZE_WORD);
  assign wr_tohost = memif.wr_addr == TOHOST_ADDR;

  assign memif.rd_data = rd_tohost ? hcode_q
                       : (rd_mis || !rd_in) ? 32'h0
                       : rd_ext;

  always_comb begin
    fault_d  = fault_q;
    cause_d  = cause_q;
    faddr_d  = faddr_q;
    halt_d   = halt_q;
    hcode_d  = hcode_q;
    wr_cnt_d = wr_cnt_q;
    ram_we   = 1'b0;
    if (memif.wr_enable) begin
      // Sub-word stores to tohost count as misaligned.
      if (wr_mis || (wr_tohost && memif.wr_size != MEM_SIZE_WORD)) begin
        if (!fault_q) begin
          fault_d = 1'b1;
          cause_d = MEM_FAULT_MISALIGNED;
          faddr_d = memif.wr_addr;
        end
      end else if (wr_tohost) begin
        if (!halt_q) begin
          halt_d  = 1'b1;
          hcode_d = memif.wr_data;
        end
      end else if (!wr_in) begin
        if (!fault_q) begin
          fault_d = 1'b1;
          cause_d = MEM_FAULT_OUT_OF_RANGE;
          faddr_d = memif.wr_addr;
        end
      end else begin
        ram_we   = 1'b1;
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fault_q  <= 1'b0;
      cause_q  <= MEM_FAULT_NONE;
      faddr_q  <= 32'h0;
      halt_q   <= 1'b0;
      hcode_q  <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      faddr_q  <= faddr_d;
      halt_q   <= halt_d;
      hcode_q  <= hcode_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // RAM is not reset; reset only blocks the write enable.
  always_ff @(posedge clk_i) begin
    if (reset_ni && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_off[AW+1:2]][8*b +: 8] <= wr_al[8*b +: 8];
        end
      end
    end
  end

  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign fault_addr_o  = faddr_q;
  assign halt_o        = halt_q;
  assign halt_code_o   = hcode_q;
  assign wr_count_o    = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level memory model.
// Directed literal checks pin the model; a compare process checks every cycle.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int          DEPTH  = 16384;
  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam logic [31:0] LIMIT  = BASE + 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_if mif ();

  logic             fault_o;
  mem_fault_cause_t fault_cause_o;
  logic [31:0]      fault_addr_o;
  logic             halt_o;
  logic [31:0]      halt_code_o;
  logic [31:0]      wr_count_o;

  dmem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .memif         (mif),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .fault_addr_o  (fault_addr_o),
    .halt_o        (halt_o),
    .halt_code_o   (halt_code_o),
    .wr_count_o    (wr_count_o)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mb [logic [31:0]];
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_faddr;
  logic        m_halt;
  logic [31:0] m_hcode;
  logic [31:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fault = 1'b0;
    m_cause = 2'd0;
    m_faddr = 32'h0;
    m_halt  = 1'b0;
    m_hcode = 32'h0;
    m_cnt   = 32'h0;
  endtask

  function automatic bit aligned(input logic [31:0] a, input logic [1:0] s);
    int n;
    n = 1 << s;
    return (a % n) == 0;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && a < LIMIT;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a,
                                        input logic [1:0] s,
                                        output bit known);
    logic [31:0] r;
    known = 1'b1;
    r = 32'h0;
    if (a == TOHOST && s == 2'd2) return m_hcode;
    if (!aligned(a, s) || !in_rng(a)) return 32'h0;
    for (int i = 0; i < (1 << s); i++) begin
      if (!mb.exists(a + 32'(i))) known = 1'b0;
      else r = r | (32'(mb[a + 32'(i)]) << (8 * i));
    end
    return r;
  endfunction

  task automatic mfault(input logic [1:0] c, input logic [31:0] a);
    if (!m_fault) begin
      m_fault = 1'b1;
      m_cause = c;
      m_faddr = a;
    end
  endtask

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
    if (!aligned(a, s) || (a == TOHOST && s != 2'd2)) begin
      mfault(2'd1, a);
    end else if (a == TOHOST) begin
      if (!m_halt) begin
        m_halt  = 1'b1;
        m_hcode = d;
      end
    end else if (!in_rng(a)) begin
      mfault(2'd2, a);
    end else begin
      for (int i = 0; i < (1 << s); i++) mb[a + 32'(i)] = d[8*i +: 8];
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Compare outputs mid-cycle, then apply the edge's write to the model.
  always begin
    logic [31:0] er;
    bit kn;
    @(negedge clk);
    if (chk_en) begin
      er = mread(mif.rd_addr, mif.rd_size, kn);
      if (kn) chk("rd_data", mif.rd_data, er);
      chk("fault_o", 32'(fault_o), 32'(m_fault));
      chk("fault_cause", 32'(fault_cause_o), 32'(m_cause));
      chk("fault_addr", fault_addr_o, m_faddr);
      chk("halt_o", 32'(halt_o), 32'(m_halt));
      chk("halt_code", halt_code_o, m_hcode);
      chk("wr_count", wr_count_o, m_cnt);
    end
    @(posedge clk);
    if (rst_n && mif.wr_enable === 1'b1)
      mwrite(mif.wr_addr, mif.wr_data, mif.wr_size);
  end

  task automatic drive(input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [1:0] ws,
                       input logic [31:0] ra, input logic [1:0] rs);
    @(posedge clk);
    #1;
    mif.wr_enable = we;
    mif.wr_addr   = wa;
    mif.wr_data   = wd;
    mif.wr_size   = ws;
    mif.rd_addr   = ra;
    mif.rd_size   = rs;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return BASE + 32'($urandom_range(0, 63));
      3: return LIMIT - 32'd16 + 32'($urandom_range(0, 15));
      4: return LIMIT + 32'($urandom_range(0, 7));
      5: return BASE - 32'd8 + 32'($urandom_range(0, 7));
      6: return TOHOST + 32'($urandom_range(0, 1) * 2);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    mif.wr_enable = 1'b0;
    mif.wr_addr   = 32'h0;
    mif.wr_data   = 32'h0;
    mif.wr_size   = 2'd0;
    mif.rd_addr   = 32'h0;
    mif.rd_size   = 2'd0;
    #12;
    chk("rst_fault", 32'(fault_o), 32'h0);
    chk("rst_cause", 32'(fault_cause_o), 32'h0);
    chk("rst_faddr", fault_addr_o, 32'h0);
    chk("rst_halt", 32'(halt_o), 32'h0);
    chk("rst_hcode", halt_code_o, 32'h0);
    chk("rst_count", wr_count_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    drive(1, 32'h0001_0004, 32'hDEAD_BEEF, 2'd2, 32'h0001_0005, 2'd0);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0001_0005, 2'd0);
    chk("lit_byte", mif.rd_data, 32'h0000_00BE);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0001_0006, 2'd1);
    chk("lit_half", mif.rd_data, 32'h0000_DEAD);
    chk("lit_cnt1", wr_count_o, 32'd1);

    drive(1, 32'h0001_0007, 32'h0000_0055, 2'd0, 32'h0001_0004, 2'd2);
    chk("lit_same_cycle", mif.rd_data, 32'hDEAD_BEEF);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0001_0004, 2'd2);
    chk("lit_byte_merge", mif.rd_data, 32'h55AD_BEEF);

    drive(1, 32'h0001_0000, 32'hA5A5_A5A5, 2'd2, 32'h0, 2'd0);
    drive(1, 32'h0001_0001, 32'h0000_1234, 2'd1, 32'h0, 2'd0);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0001_0000, 2'd2);
    chk("lit_mis_noram", mif.rd_data, 32'hA5A5_A5A5);
    chk("lit_mis_fault", 32'(fault_o), 32'h1);
    chk("lit_mis_cause", 32'(fault_cause_o), 32'h1);
    chk("lit_mis_addr", fault_addr_o, 32'h0001_0001);
    drive(1, 32'h0000_0000, 32'hCAFE_F00D, 2'd2, 32'h0, 2'd0);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0, 2'd0);
    chk("lit_sticky_cause", 32'(fault_cause_o), 32'h1);
    chk("lit_sticky_addr", fault_addr_o, 32'h0001_0001);
    chk("lit_cnt3", wr_count_o, 32'd3);

    drive(1, TOHOST, 32'h1, 2'd2, 32'h0, 2'd0);
    drive(1, TOHOST, 32'h2, 2'd2, TOHOST, 2'd2);
    drive(0, 32'h0, 32'h0, 2'd0, TOHOST, 2'd2);
    chk("lit_halt", 32'(halt_o), 32'h1);
    chk("lit_hcode", halt_code_o, 32'h1);
    chk("lit_halt_cnt", wr_count_o, 32'd3);
    chk("lit_tohost_rd", mif.rd_data, 32'h1);

    drive(0, 32'h0, 32'h0, 2'd0, 32'h0, 2'd0);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    drive(1, 32'h0001_0008, 32'h1122_3344, 2'd2, 32'h0, 2'd0);
    drive(0, 32'h0, 32'h0, 2'd0, 32'h0001_0008, 2'd2);
    chk("lit_wrap", wr_count_o, 32'h0);
    chk("lit_after_halt", mif.rd_data, 32'h1122_3344);

    drive(1, 32'h0001_0004, 32'h0BAD_F00D, 2'd2, 32'h0001_0004, 2'd2);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_arst_fault", 32'(fault_o), 32'h0);
    chk("lit_arst_cause", 32'(fault_cause_o), 32'h0);
    chk("lit_arst_faddr", fault_addr_o, 32'h0);
    chk("lit_arst_halt", 32'(halt_o), 32'h0);
    chk("lit_arst_hcode", halt_code_o, 32'h0);
    chk("lit_arst_cnt", wr_count_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mif.wr_enable = 1'b0;
    @(negedge clk);
    #1;
    chk("lit_ram_kept", mif.rd_data, 32'h55AD_BEEF);

    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), pick_addr(), $urandom,
            2'($urandom_range(0, 2)), pick_addr(),
            2'($urandom_range(0, 2)));
    end

    drive(0, 32'h0, 32'h0, 2'd0, 32'h0, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00010000, byte address of RAM word 0.
REQ-002 Parameter DEPTH_WORDS, default 16384, RAM depth in 32-bit words; power of two.
REQ-003 Parameter TOHOST_ADDR, default 32'h80001000, word-aligned MMIO halt register address.
REQ-004 clk_i  input  1  sole clock; all state updates on posedge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 memif  mem_if.master  -  responder end of the memory interface: rd_addr, rd_size, wr_addr, wr_data, wr_size and wr_enable are inputs; rd_data is output.
REQ-007 fault_o  output  1  sticky write-fault flag.
REQ-008 fault_cause_o  output  mem_fault_cause_t  cause of the first fault.
REQ-009 fault_addr_o  output  32  wr_addr of the first fault.
REQ-010 halt_o  output  1  sticky; set by the first TOHOST write.
REQ-011 halt_code_o  output  32  wr_data of the first TOHOST write.
REQ-012 wr_count_o  output  32  count of committed RAM writes.

Function
REQ-013 Reads are combinational, with zero latency: rd_data reflects the current rd_addr/rd_size and the RAM contents before the current edge.
REQ-014 Read extraction:
- WORD returns the full word.
- HALF returns the halfword selected by addr[1], zero-extended.
- BYTE returns the byte selected by addr[1:0], zero-extended.
- Sign extension is the requester's job.
REQ-015 A read that is misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0) or outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) returns 0 and raises no fault; pipeline bubbles present arbitrary addresses.
REQ-016 A read at TOHOST_ADDR (WORD) returns halt_code_o.
REQ-017 A write commits at the posedge where wr_enable=1.
- The byte-lane mask is derived from wr_size and wr_addr[1:0].
- Data is taken from the low bits of wr_data, replicated to the selected lane(s).
- Unselected bytes are unchanged.
REQ-018 Same-cycle read and write to the same word: rd_data returns the old data; the new data is visible the following cycle.
REQ-019 A write that is misaligned (cause MISALIGNED) or out of range and not TOHOST (cause OUT_OF_RANGE) is suppressed: no RAM change, no count.
- If fault_o=0, the edge sets fault_o and captures fault_cause_o and fault_addr_o.
- Later faults are ignored until reset.
REQ-020 A WORD write to TOHOST_ADDR does not touch RAM and does not increment wr_count_o.
- If halt_o=0, it sets halt_o and captures halt_code_o.
- Later TOHOST writes are ignored.
- A non-WORD write to TOHOST_ADDR is a MISALIGNED fault.
REQ-021 wr_count_o increments by 1 per committed RAM write and wraps from 32'hFFFFFFFF to 0.
REQ-022 halt_o does not block further RAM writes or reads.

Reset
REQ-023 Reset drives fault_o=0, fault_cause_o=MEM_FAULT_NONE, fault_addr_o=0, halt_o=0, halt_code_o=0 and wr_count_o=0 immediately, independent of clk_i.
REQ-024 RAM contents are not reset; a write coincident with an asserted reset does not commit.
REQ-025 After reset deasserts, the first committing edge behaves as REQ-017..REQ-021.

Structure
REQ-026 mem_fault_cause_t (MEM_FAULT_NONE, MEM_FAULT_MISALIGNED, MEM_FAULT_OUT_OF_RANGE) lives in the definitions package next to the existing mem-access size encodings.
REQ-027 Lane-mask and extraction logic lives in one sub-module, mem_lane_align (combinational: size and addr[1:0] in; byte mask, aligned write data, extracted read data and misaligned flag out).
REQ-028 RAM is a single word array inferable as block RAM with byte-enable write.

Verification
REQ-029 Write WORD 32'hDEADBEEF @0x00010004; read BYTE @0x00010005 -> 32'h000000BE; read HALF @0x00010006 -> 32'h0000DEAD; wr_count_o=1.
REQ-030 Write BYTE 8'h55 @0x00010007 over 32'hDEADBEEF; read WORD @0x00010004 -> 32'h55ADBEEF; same-cycle read -> 32'hDEADBEEF.
REQ-031 Write HALF @0x00010001 -> no RAM change; fault_o=1, cause MISALIGNED, fault_addr_o=0x00010001. Then write WORD @0x00000000 -> fault fields unchanged.
REQ-032 Write WORD 32'h1 @TOHOST_ADDR then 32'h2 -> halt_o=1, halt_code_o=32'h1; wr_count_o unchanged; read WORD @TOHOST_ADDR -> 32'h1.
REQ-033 Preload wr_count_o to 32'hFFFFFFFF via writes/force, commit one write -> 0. Assert reset_ni mid-cycle -> all outputs clear before the next edge; RAM data is retained.
